sound_output: RTL and testbench

Audio output stage for the Interact SN76477 model. It consumes the 14-bit unsigned `magnitude` from `sound_generator` at the 24.576 MHz audio clock and box-car decimates it to 48 kHz. It then applies the Interact half-volume control and an optional DC-blocking high-pass, and presents a signed 16-bit PCM sample with a one-cycle valid strobe to the platform audio mixer.

---
 rtl/sound_output_if.sv | 11 +
 rtl/sound_output.sv | 72 +++++++
 tb/tb_sound_output.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sound_output_if.sv
// Sample bus between the sound generator level source and the platform mixer.
interface sound_output_if;
    logic [13:0] magnitude;
    logic        half_volume;
    logic        mute;
    logic [15:0] sample;
    logic        sample_valid;

    modport master (output magnitude, half_volume, mute, input sample, sample_valid);
    modport slave  (input magnitude, half_volume, mute, output sample, sample_valid);
endinterface

// File: rtl/sound_output.sv
// Interact audio output: 512:1 box-car decimation to 48 kHz, half-volume,
// optional DC-blocking high-pass, signed 16-bit PCM with a one-cycle strobe.
module sound_output #(
    parameter int DC_BLOCK = 1,
    parameter int DC_SHIFT = 10
) (
    input  logic          clk_audio,
    input  logic          rst_n,
    sound_output_if.slave snd
);
    logic [8:0]         phase;
    logic [22:0]        acc;
    logic [22:0]        acc_sum;
    logic [13:0]        avg;
    logic [13:0]        lvl;
    logic [23:0]        dc;
    logic [23:0]        dc_next;
    logic signed [24:0] dc_err;
    logic signed [14:0] s;
    logic [15:0]        sample_q;
    // [0] avg written, [1] lvl written, [2] sample written (the output strobe)
    logic [2:0]         vld_pipe;

    assign acc_sum          = acc + {9'd0, snd.magnitude};
    assign snd.sample       = sample_q;
    assign snd.sample_valid = vld_pipe[2];

    // Tracker error is taken in 25-bit signed so the arithmetic shift keeps
    // the sign when the level drops below the tracked DC.
    always_comb begin
        dc_err  = '0;
        dc_next = dc;
        s       = $signed({1'b0, lvl});
        if (DC_BLOCK != 0) begin
            s       = $signed({1'b0, lvl}) - $signed({1'b0, dc[23:10]});
            dc_err  = $signed({1'b0, lvl, 10'd0}) - $signed({1'b0, dc});
            dc_next = 24'($signed({1'b0, dc}) + (dc_err >>> DC_SHIFT));
        end
    end

    always_ff @(posedge clk_audio) begin
        if (!rst_n) begin
            phase    <= '0;
            acc      <= '0;
            avg      <= '0;
            lvl      <= '0;
            dc       <= '0;
            sample_q <= '0;
            vld_pipe <= '0;
        end else begin
            phase    <= phase + 9'd1;
            vld_pipe <= {vld_pipe[1:0], phase == 9'd511};

            // Last input of the window is folded in on the closing edge.
            if (phase == 9'd511) begin
                avg <= acc_sum[22:9];
                acc <= '0;
            end else begin
                acc <= acc_sum;
            end

            if (vld_pipe[0])
                lvl <= snd.half_volume ? {1'b0, avg[13:1]} : avg;

            // dc keeps tracking while muted so unmuting follows the normal curve.
            if (vld_pipe[1]) begin
                dc       <= dc_next;
                sample_q <= snd.mute ? 16'd0 : {s, 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_sound_output.sv
// Directed bench for sound_output: one DUT without and one with DC blocking.
module tb_sound_output;
    localparam int DCS = 10;

    typedef struct {
        logic [13:0] ma;
        logic [13:0] mb;
        logic        h;
        logic        m;
        int          e0;
    } vec_t;

    logic        clk_audio = 1'b0;
    logic        rst_n     = 1'b0;
    logic [13:0] mag       = '0;
    logic        hv        = 1'b0;
    logic        mu        = 1'b0;

    int     checks = 0;
    int     errors = 0;
    bit     pend = 0;
    bit     have_last = 0;
    int     pend_e0, pend_e1, last_e0, last_e1;
    int     last1;
    longint dcm = 0;
    vec_t   tbl [13];

    always #5 clk_audio = ~clk_audio;

    sound_output_if if0 ();
    sound_output_if if1 ();
    assign if0.magnitude   = mag;
    assign if0.half_volume = hv;
    assign if0.mute        = mu;
    assign if1.magnitude   = mag;
    assign if1.half_volume = hv;
    assign if1.mute        = mu;

    sound_output #(.DC_BLOCK(0), .DC_SHIFT(DCS)) dut0 (.clk_audio(clk_audio), .rst_n(rst_n), .snd(if0));
    sound_output #(.DC_BLOCK(1), .DC_SHIFT(DCS)) dut1 (.clk_audio(clk_audio), .rst_n(rst_n), .snd(if1));

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // One window of len edges: ma for the first 256 inputs, mb for the rest.
    // Controls for this window's sample are set after the previous sample's
    // control edges have passed. Full windows queue an expected strobe.
    task automatic run_win(input logic [13:0] ma, input logic [13:0] mb,
                           input logic h, input logic m, input int e0, input int len);
        int stray = 0;
        int avg, lvl, s;
        mag = ma;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk_audio);
            if (k == 2 && pend) begin
                chk("strobe0", int'(if0.sample_valid), 1);
                chk("strobe1", int'(if1.sample_valid), 1);
                chk("sample0", s16(if0.sample), pend_e0);
                chk("sample1", s16(if1.sample), pend_e1);
                last1     = s16(if1.sample);
                last_e0   = pend_e0;
                last_e1   = pend_e1;
                pend      = 0;
                have_last = 1;
            end else if (if0.sample_valid || if1.sample_valid) begin
                stray++;
            end
            if (k == 2) begin
                hv = h;
                mu = m;
            end
            if (k == 256) mag = mb;
            if (k == 300 && have_last) begin
                chk("hold0", s16(if0.sample), last_e0);
                chk("hold1", s16(if1.sample), last_e1);
            end
        end
        chk("stray_strobe", stray, 0);
        if (len == 512) begin
            avg     = (int'(ma) * 256 + int'(mb) * 256) >> 9;
            lvl     = h ? (avg >> 1) : avg;
            s       = lvl - int'(dcm >>> 10);
            dcm     = dcm + (((longint'(lvl) <<< 10) - dcm) >>> DCS);
            pend_e0 = e0;
            pend_e1 = m ? 0 : 2 * s;
            pend    = 1;
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_audio);
            if (i == 0) begin
                chk("rst_sample0", s16(if0.sample), 0);
                chk("rst_valid0", int'(if0.sample_valid), 0);
                chk("rst_sample1", s16(if1.sample), 0);
                chk("rst_valid1", int'(if1.sample_valid), 0);
            end
        end
        rst_n     = 1'b1;
        pend      = 0;
        have_last = 0;
        dcm       = 0;
    endtask

    initial begin
        int prev;
        tbl[0]  = '{14'd1000,  14'd1000,  1'b0, 1'b0, 2000};
        tbl[1]  = '{14'd1000,  14'd1000,  1'b0, 1'b0, 2000};
        tbl[2]  = '{14'd1000,  14'd1000,  1'b1, 1'b0, 1000};
        tbl[3]  = '{14'd8192,  14'd0,     1'b0, 1'b0, 8192};
        tbl[4]  = '{14'd16383, 14'd16383, 1'b0, 1'b0, 32766};
        tbl[5]  = '{14'd16383, 14'd16383, 1'b1, 1'b0, 16382};
        tbl[6]  = '{14'd511,   14'd511,   1'b0, 1'b0, 1022};
        tbl[7]  = '{14'd1,     14'd1,     1'b0, 1'b0, 2};
        tbl[8]  = '{14'd3,     14'd0,     1'b0, 1'b0, 2};
        tbl[9]  = '{14'd5000,  14'd5000,  1'b0, 1'b1, 0};
        tbl[10] = '{14'd5000,  14'd5000,  1'b0, 1'b0, 10000};
        tbl[11] = '{14'd2,     14'd2,     1'b1, 1'b0, 2};
        tbl[12] = '{14'd3,     14'd3,     1'b1, 1'b0, 2};

        // First strobe lands on edge 2 of the second window, 514 edges in.
        do_reset(2);
        foreach (tbl[i]) run_win(tbl[i].ma, tbl[i].mb, tbl[i].h, tbl[i].m, tbl[i].e0, 512);

        // Reset mid-window at phase 300: partial window and pending strobe dropped.
        run_win(14'd777, 14'd777, 1'b0, 1'b0, 0, 300);
        do_reset(1);
        run_win(14'd1000, 14'd1000, 1'b0, 1'b0, 2000, 512);
        run_win(14'd1000, 14'd1000, 1'b0, 1'b0, 2000, 512);

        // Reset one cycle after a window close: in-flight sample cancelled.
        do_reset(1);
        run_win(14'd1000, 14'd1000, 1'b0, 1'b0, 2000, 512);

        // DC-blocker step response from a clean tracker.
        do_reset(2);
        run_win(14'd0, 14'd0, 1'b0, 1'b0, 0, 512);
        run_win(14'd8192, 14'd8192, 1'b0, 1'b0, 16384, 512);
        run_win(14'd8192, 14'd8192, 1'b0, 1'b0, 16384, 512);
        chk("step_first", last1, 16384);
        run_win(14'd8192, 14'd8192, 1'b0, 1'b0, 16384, 512);
        chk("step_second", last1, 16368);
        for (int i = 0; i < 12; i++) begin
            prev = last1;
            run_win(14'd8192, 14'd8192, 1'b0, 1'b0, 16384, 512);
            chk("decay_monotone", int'(last1 <= prev), 1);
        end

        // Mute three windows; tracker keeps moving underneath.
        for (int i = 0; i < 3; i++) run_win(14'd8192, 14'd8192, 1'b0, 1'b1, 0, 512);
        for (int i = 0; i < 4; i++) run_win(14'd8192, 14'd8192, 1'b0, 1'b0, 16384, 512);
        run_win(14'd0, 14'd0, 1'b0, 1'b0, 0, 512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
